spi_flash_loader: RTL and testbench

- Hardware sequencer that drives the SPI master controller's memory-mapped register port to perform a standard serial-flash READ (0x03 + 24-bit address).
- Streams the returned bytes, packed little-endian into 32-bit words, into an on-chip memory write port, e.g. weight/config SRAM at boot.
- Sits between the SoC boot/config logic (start/done) and the SPI controller's `req_*`/`rdata` port, replacing firmware polling.

---
 rtl/spi_pkg.sv | 37 +++
 rtl/spi_byte_packer.sv | 90 +++++++++
 rtl/spi_flash_loader.sv | 185 ++++++++++++++++++
 tb/tb_spi_flash_loader.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI flash loader: register offsets of the SPI
// master controller, CTRL/STATUS bit positions, the serial-flash READ opcode
// and the loader state encoding.
// ---------------------------------------------------------------------------
package spi_pkg;

  // Register offsets relative to the controller base address
  localparam logic [31:0] SPI_OFF_CTRL   = 32'h00;
  localparam logic [31:0] SPI_OFF_STATUS = 32'h04;
  localparam logic [31:0] SPI_OFF_TXDATA = 32'h08;
  localparam logic [31:0] SPI_OFF_RXDATA = 32'h0C;

  // CTRL and STATUS bit positions
  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_DIV_LSB   = 1;
  localparam int CTRL_CS_BIT    = 8;
  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_RXV_BIT   = 1;

  // Standard serial-flash READ opcode and header length (opcode + 3 address bytes)
  localparam logic [7:0] FLASH_READ_OP = 8'h03;
  localparam int         HEADER_BYTES  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_TX_WR,
    S_POLL,
    S_RX_RD,
    S_MEM_WR,
    S_RELEASE,
    S_DONE
  } loader_state_t;

endpackage

// File: rtl/spi_byte_packer.sv
// ---------------------------------------------------------------------------
// spi_byte_packer
// Packs received data bytes little-endian into 32-bit words and issues one
// registered memory write per completed (or final partial) word.
//   clear     : restart packing at dst_base (word index 0, empty buffer)
//   dst_base  : destination byte address, bits [1:0] ignored
//   byte_in   : data byte, qualified by valid
//   valid     : byte_in carries the next data byte
//   last      : this is the final data byte of the transfer
//   mem_*     : word write port, asserted the cycle after the closing byte
// ---------------------------------------------------------------------------
module spi_byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic [31:0] dst_base,
  input  logic [7:0]  byte_in,
  input  logic        valid,
  input  logic        last,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb
);

  logic [1:0]  lane_q;
  logic [31:0] word_q;
  logic [3:0]  strb_q;
  logic [29:0] base_q;
  logic [29:0] word_idx_q;

  logic [31:0] word_nx;
  logic [3:0]  strb_nx;
  logic        flush;

  logic unused_base_bits;
  assign unused_base_bits = ^dst_base[1:0];

  // Merge the incoming byte into its lane; a word is flushed when lane 3
  // fills or the transfer ends on a partial word.
  always_comb begin
    word_nx = word_q | (32'(byte_in) << {lane_q, 3'b000});
    strb_nx = strb_q | (4'b0001 << lane_q);
    flush   = valid && ((lane_q == 2'd3) || last);
  end

  // Buffer, lane and word-index state plus the registered write port. The
  // write outputs return to zero in every cycle that carries no write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q     <= 2'd0;
      word_q     <= 32'd0;
      strb_q     <= 4'd0;
      base_q     <= 30'd0;
      word_idx_q <= 30'd0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      mem_wstrb  <= 4'd0;
    end else begin
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_wstrb <= 4'd0;
      if (clear) begin
        lane_q     <= 2'd0;
        word_q     <= 32'd0;
        strb_q     <= 4'd0;
        base_q     <= dst_base[31:2];
        word_idx_q <= 30'd0;
      end else if (valid) begin
        if (flush) begin
          mem_we     <= 1'b1;
          mem_addr   <= {base_q + word_idx_q, 2'b00};
          mem_wdata  <= word_nx;
          mem_wstrb  <= strb_nx;
          word_idx_q <= word_idx_q + 30'd1;
          lane_q     <= 2'd0;
          word_q     <= 32'd0;
          strb_q     <= 4'd0;
        end else begin
          lane_q <= lane_q + 2'd1;
          word_q <= word_nx;
          strb_q <= strb_nx;
        end
      end
    end
  end

endmodule

// File: rtl/spi_flash_loader.sv
// ---------------------------------------------------------------------------
// spi_flash_loader
// Sequences a serial-flash READ (0x03 + 24-bit address) through the SPI
// master controller's register port and streams the returned bytes into an
// on-chip memory as little-endian 32-bit words.
//   start/flash_addr/byte_count/dst_base : request, sampled on accepted start
//   busy/done/err                        : status; err is a sticky timeout flag
//   m_req_* / m_rdata                    : SPI controller register port
//   mem_*                                : destination memory write port
// ---------------------------------------------------------------------------
module spi_flash_loader
  import spi_pkg::*;
#(
  parameter logic [31:0] SPI_BASE     = 32'h0,
  parameter logic [2:0]  CLK_DIV      = 3'd1,
  parameter int          POLL_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] flash_addr,
  input  logic [15:0] byte_count,
  input  logic [31:0] dst_base,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        m_req_valid,
  output logic        m_req_write,
  output logic [31:0] m_req_addr,
  output logic [31:0] m_req_wdata,
  output logic [3:0]  m_req_wstrb,
  input  logic [31:0] m_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb
);

  localparam int PCW = $clog2(POLL_TIMEOUT) + 1;
  localparam logic [31:0] CTRL_ON =
    (32'd1 << CTRL_CS_BIT) | (32'd1 << CTRL_EN_BIT) | (32'(CLK_DIV) << CTRL_DIV_LSB);

  loader_state_t  state, state_nx;
  logic [23:0]    flash_addr_q;
  logic [15:0]    byte_count_q;
  logic [16:0]    xfer_idx;
  logic [PCW-1:0] poll_cnt;
  logic           err_q;

  logic [7:0]  tx_byte;
  logic        is_data;
  logic        last_xfer;
  logic        all_done;
  logic        poll_ready;
  logic        poll_expired;
  logic        accept;
  logic [31:0] req_off;

  logic unused_rdata_bits;
  assign unused_rdata_bits = ^m_rdata[31:8];

  // Transfer bookkeeping: xfer_idx counts SPI byte transfers, the first
  // four being the READ header whose received bytes are discarded.
  always_comb begin
    accept       = (state == S_IDLE) && start;
    is_data      = (xfer_idx >= 17'(HEADER_BYTES));
    last_xfer    = (xfer_idx == {1'b0, byte_count_q} + 17'(HEADER_BYTES - 1));
    all_done     = (xfer_idx == {1'b0, byte_count_q} + 17'(HEADER_BYTES));
    poll_ready   = m_rdata[STAT_RXV_BIT] && !m_rdata[STAT_BUSY_BIT];
    poll_expired = (poll_cnt == PCW'(POLL_TIMEOUT - 1));
    case (xfer_idx)
      17'd0:   tx_byte = FLASH_READ_OP;
      17'd1:   tx_byte = flash_addr_q[23:16];
      17'd2:   tx_byte = flash_addr_q[15:8];
      17'd3:   tx_byte = flash_addr_q[7:0];
      default: tx_byte = 8'h00;
    endcase
  end

  // Next-state and register-port request decode. A zero-length request
  // spends its single busy cycle in CFG without touching the controller.
  always_comb begin
    state_nx    = state;
    m_req_valid = 1'b0;
    m_req_write = 1'b0;
    req_off     = 32'd0;
    m_req_wdata = 32'd0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_CFG;
      end
      S_CFG: begin
        if (byte_count_q == 16'd0) begin
          state_nx = S_DONE;
        end else begin
          m_req_valid = 1'b1;
          m_req_write = 1'b1;
          req_off     = SPI_OFF_CTRL;
          m_req_wdata = CTRL_ON;
          state_nx    = S_TX_WR;
        end
      end
      S_TX_WR: begin
        m_req_valid = 1'b1;
        m_req_write = 1'b1;
        req_off     = SPI_OFF_TXDATA;
        m_req_wdata = {24'd0, tx_byte};
        state_nx    = S_POLL;
      end
      S_POLL: begin
        m_req_valid = 1'b1;
        req_off     = SPI_OFF_STATUS;
        if (poll_ready)        state_nx = S_RX_RD;
        else if (poll_expired) state_nx = S_RELEASE;
      end
      S_RX_RD: begin
        m_req_valid = 1'b1;
        req_off     = SPI_OFF_RXDATA;
        if (is_data && ((xfer_idx[1:0] == 2'b11) || last_xfer)) state_nx = S_MEM_WR;
        else                                                    state_nx = S_TX_WR;
      end
      S_MEM_WR: begin
        state_nx = all_done ? S_RELEASE : S_TX_WR;
      end
      S_RELEASE: begin
        m_req_valid = 1'b1;
        m_req_write = 1'b1;
        req_off     = SPI_OFF_CTRL;
        state_nx    = S_DONE;
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign m_req_addr  = m_req_valid ? SPI_BASE + req_off : 32'd0;
  assign m_req_wstrb = m_req_valid ? 4'hF : 4'h0;
  assign busy        = (state != S_IDLE) && (state != S_DONE);
  assign done        = (state == S_DONE);
  assign err         = err_q;

  // State register, latched request, transfer index, poll counter and the
  // sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      flash_addr_q <= 24'd0;
      byte_count_q <= 16'd0;
      xfer_idx     <= 17'd0;
      poll_cnt     <= '0;
      err_q        <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        flash_addr_q <= flash_addr;
        byte_count_q <= byte_count;
        xfer_idx     <= 17'd0;
        err_q        <= 1'b0;
      end
      if (state == S_TX_WR) poll_cnt <= '0;
      if ((state == S_POLL) && !poll_ready) begin
        if (poll_expired) err_q    <= 1'b1;
        else              poll_cnt <= poll_cnt + 1'b1;
      end
      if (state == S_RX_RD) xfer_idx <= xfer_idx + 17'd1;
    end
  end

  spi_byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (accept),
    .dst_base  (dst_base),
    .byte_in   (m_rdata[7:0]),
    .valid     ((state == S_RX_RD) && is_data),
    .last      (last_xfer),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb)
  );

endmodule

// File: tb/tb_spi_flash_loader.sv
// ---------------------------------------------------------------------------
// tb_spi_flash_loader
// Drives spi_flash_loader against a behavioural SPI register-port model with
// an attached Mode-0 READ flash, and compares memory writes, MOSI bytes,
// poll counts and status against expectations derived from the flash image.
// ---------------------------------------------------------------------------
module tb_spi_flash_loader;

  localparam logic [31:0] SPI_BASE     = 32'h4000_0000;
  localparam int          CLK_DIV      = 7;
  localparam int          POLL_TIMEOUT = 300;
  localparam int          SHIFT        = 16 * (CLK_DIV + 1);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [23:0] flash_addr;
  logic [15:0] byte_count;
  logic [31:0] dst_base;
  logic        busy, done, err;
  logic        m_req_valid, m_req_write;
  logic [31:0] m_req_addr, m_req_wdata;
  logic [3:0]  m_req_wstrb;
  logic [31:0] m_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  wr_t         wr_q[$];
  logic [31:0] ctrl_q[$];
  logic [7:0]  mosi_q[$];
  int          req_cnt  = 0;
  int          poll_cnt = 0;
  int          checks   = 0;
  int          errors   = 0;

  logic [7:0]  flash_mem [256];
  bit          force_off = 1'b0;

  logic [31:0] spi_ctrl;
  int          shift_left;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  int          flash_pos;
  logic [23:0] rd_addr;
  logic [31:0] req_off;
  logic        cs_high;

  spi_flash_loader #(
    .SPI_BASE     (SPI_BASE),
    .CLK_DIV      (3'(CLK_DIV)),
    .POLL_TIMEOUT (POLL_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .flash_addr  (flash_addr),
    .byte_count  (byte_count),
    .dst_base    (dst_base),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .m_req_valid (m_req_valid),
    .m_req_write (m_req_write),
    .m_req_addr  (m_req_addr),
    .m_req_wdata (m_req_wdata),
    .m_req_wstrb (m_req_wstrb),
    .m_rdata     (m_rdata),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb)
  );

  // Free-running clock
  always #5 clk = ~clk;

  assign req_off = m_req_addr - SPI_BASE;
  assign cs_high = !(spi_ctrl[8] && spi_ctrl[0]);

  // SPI controller plus flash model: a TXDATA write while enabled shifts for
  // 16*(div+1) cycles, then raises rx_valid with the flash's reply. The flash
  // answers 0xFF during the header and its image from the captured address after.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_ctrl   <= 32'd0;
      shift_left <= 0;
      rx_valid   <= 1'b0;
      rx_byte    <= 8'd0;
      flash_pos  <= 0;
      rd_addr    <= 24'd0;
    end else begin
      if (shift_left > 0) begin
        shift_left <= shift_left - 1;
        if (shift_left == 1) rx_valid <= 1'b1;
      end
      if (m_req_valid && m_req_write && req_off == 32'h0) begin
        spi_ctrl <= m_req_wdata;
        if (!(m_req_wdata[8] && m_req_wdata[0])) flash_pos <= 0;
      end
      if (m_req_valid && m_req_write && req_off == 32'h8 && spi_ctrl[0] && !force_off) begin
        shift_left <= 16 * (int'(spi_ctrl[3:1]) + 1);
        rx_valid   <= 1'b0;
        mosi_q.push_back(m_req_wdata[7:0]);
        if (flash_pos >= 4) rx_byte <= flash_mem[rd_addr[7:0] + 8'(flash_pos - 4)];
        else                rx_byte <= 8'hFF;
        case (flash_pos)
          1: rd_addr[23:16] <= m_req_wdata[7:0];
          2: rd_addr[15:8]  <= m_req_wdata[7:0];
          3: rd_addr[7:0]   <= m_req_wdata[7:0];
          default: ;
        endcase
        flash_pos <= flash_pos + 1;
      end
      if (m_req_valid && !m_req_write && req_off == 32'hC) rx_valid <= 1'b0;
    end
  end

  // Combinational register read data of the controller model
  always_comb begin
    m_rdata = 32'd0;
    if (m_req_valid && !m_req_write) begin
      if (req_off == 32'h4)      m_rdata = {30'd0, rx_valid, shift_left != 0};
      else if (req_off == 32'hC) m_rdata = {24'd0, rx_byte};
    end
  end

  // Monitor on the falling edge: counts requests and polls, records CTRL
  // writes and memory writes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_req_valid) begin
        req_cnt++;
        if (!m_req_write && req_off == 32'h4) poll_cnt++;
        if (m_req_write && req_off == 32'h0) ctrl_q.push_back(m_req_wdata);
      end
      if (mem_we) wr_q.push_back('{addr: mem_addr, data: mem_wdata, strb: mem_wstrb});
    end
  end

  // Single comparison point for every check in the bench
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Runs one loader request and compares the outcome with what the flash
  // image and the READ protocol dictate.
  task automatic applyStimulus(input logic [23:0] a, input int n, input logic [31:0] d,
                               input bit poke, input bit exp_timeout);
    int  wr0   = wr_q.size();
    int  ctrl0 = ctrl_q.size();
    int  mosi0 = mosi_q.size();
    int  req0  = req_cnt;
    int  poll0 = poll_cnt;
    int  bound = exp_timeout ? POLL_TIMEOUT + 50 : (4 + n) * (SHIFT + 6) + 50;
    int  cycles = 0;
    bit  seen = 1'b0;
    logic [31:0] ed;
    logic [3:0]  es;
    logic [7:0]  em;
    wr_t         w;

    @(negedge clk);
    start = 1'b1; flash_addr = a; byte_count = 16'(n); dst_base = d;
    @(negedge clk);
    start = 1'b0;
    flash_addr = 24'($urandom); byte_count = 16'($urandom); dst_base = $urandom;
    checkOutput("busy_rise", {31'd0, busy}, 32'd1);
    checkOutput("err_clear", {31'd0, err}, 32'd0);
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (poke && i == 40) begin
        start = 1'b1; flash_addr = 24'($urandom); byte_count = 16'($urandom_range(1, 20));
        dst_base = $urandom;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1'b1; cycles = i;
        break;
      end
    end
    start = 1'b0;
    checkOutput("done_seen", {31'd0, seen}, 32'd1);
    checkOutput("done_err", {31'd0, err}, {31'd0, exp_timeout});
    checkOutput("busy_at_done", {31'd0, busy}, 32'd0);
    @(negedge clk);
    checkOutput("done_pulse", {31'd0, done}, 32'd0);
    checkOutput("cs_high", {31'd0, cs_high}, 32'd1);

    if (n == 0) begin
      checkOutput("zero_latency", cycles, 1);
      checkOutput("zero_req", req_cnt - req0, 0);
      checkOutput("zero_wr", wr_q.size() - wr0, 0);
    end else if (exp_timeout) begin
      checkOutput("to_polls", poll_cnt - poll0, POLL_TIMEOUT);
      checkOutput("to_wr", wr_q.size() - wr0, 0);
      checkOutput("to_ctrl_n", ctrl_q.size() - ctrl0, 2);
      if (ctrl_q.size() > 0) checkOutput("to_ctrl_last", ctrl_q[ctrl_q.size() - 1], 32'h0);
    end else begin
      checkOutput("wr_count", wr_q.size() - wr0, (n + 3) / 4);
      for (int wi = 0; wi < (n + 3) / 4; wi++) begin
        ed = 32'd0; es = 4'd0;
        for (int k = wi * 4; k < n && k < wi * 4 + 4; k++) begin
          ed = ed | (32'(flash_mem[8'(a + 24'(k))]) << (8 * (k % 4)));
          es = es | 4'(1 << (k % 4));
        end
        if (wr0 + wi < wr_q.size()) begin
          w = wr_q[wr0 + wi];
          checkOutput("wr_addr", w.addr, (d & 32'hFFFF_FFFC) + 32'(4 * wi));
          checkOutput("wr_data", w.data, ed);
          checkOutput("wr_strb", {28'd0, w.strb}, {28'd0, es});
        end
      end
      checkOutput("mosi_count", mosi_q.size() - mosi0, 4 + n);
      for (int j = 0; j < 4 + n && mosi0 + j < mosi_q.size(); j++) begin
        em = (j == 0) ? 8'h03 : (j == 1) ? a[23:16] : (j == 2) ? a[15:8] : (j == 3) ? a[7:0] : 8'h00;
        checkOutput("mosi_byte", {24'd0, mosi_q[mosi0 + j]}, {24'd0, em});
      end
      checkOutput("poll_total", poll_cnt - poll0, (4 + n) * (SHIFT + 1));
      checkOutput("ctrl_n", ctrl_q.size() - ctrl0, 2);
      if (ctrl_q.size() >= ctrl0 + 2) begin
        checkOutput("ctrl_on", ctrl_q[ctrl0], 32'h101 | 32'(CLK_DIV << 1));
        checkOutput("ctrl_off", ctrl_q[ctrl0 + 1], 32'h0);
      end
    end
  endtask

  // Scenario sequence: directed cases first, then randomized requests
  initial begin
    int wr0;
    rst_n = 1'b0; start = 1'b0; flash_addr = 24'd0; byte_count = 16'd0; dst_base = 32'd0;
    for (int i = 0; i < 256; i++) flash_mem[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) flash_mem[8'h45 + i] = 8'(i);
    #1;
    checkOutput("reset_outs",
                {21'd0, busy, done, err, m_req_valid, m_req_write, |m_req_addr, |m_req_wdata,
                 |m_req_wstrb, mem_we, |mem_addr, |mem_wdata},
                32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed READ, 8 bytes");
    wr0 = wr_q.size();
    applyStimulus(24'h012345, 8, 32'h1000, 1'b0, 1'b0);
    if (wr_q.size() >= wr0 + 2) begin
      checkOutput("t1_word0", wr_q[wr0].data, 32'h03020100);
      checkOutput("t1_word1", wr_q[wr0 + 1].data, 32'h07060504);
      checkOutput("t1_addr1", wr_q[wr0 + 1].addr, 32'h1004);
    end

    $display("[TB] 6 bytes, unaligned destination");
    wr0 = wr_q.size();
    applyStimulus(24'($urandom), 6, 32'h2003, 1'b0, 1'b0);
    if (wr_q.size() >= wr0 + 2) begin
      checkOutput("t2_addr0", wr_q[wr0].addr, 32'h2000);
      checkOutput("t2_strb1", {28'd0, wr_q[wr0 + 1].strb}, 32'h3);
    end

    $display("[TB] zero-length request");
    applyStimulus(24'($urandom), 0, $urandom, 1'b0, 1'b0);

    $display("[TB] controller disabled, expect timeout");
    force_off = 1'b1;
    applyStimulus(24'($urandom), 3, $urandom, 1'b0, 1'b1);
    force_off = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("err_sticky", {31'd0, err}, 32'd1);

    $display("[TB] start pulsed mid-transfer");
    applyStimulus(24'($urandom), 5, $urandom, 1'b1, 1'b0);

    $display("[TB] reset mid-transfer");
    @(negedge clk);
    start = 1'b1; flash_addr = 24'h00ABCD; byte_count = 16'd8; dst_base = 32'h3000;
    @(negedge clk);
    start = 1'b0;
    repeat (60) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_outs",
                {21'd0, busy, done, err, m_req_valid, m_req_write, |m_req_addr, |m_req_wdata,
                 |m_req_wstrb, mem_we, |mem_addr, |mem_wdata},
                32'd0);
    @(negedge clk);
    checkOutput("midrst_cs", {31'd0, cs_high}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_idle", {30'd0, busy, m_req_valid}, 32'd0);

    $display("[TB] randomized requests");
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 256; i++) flash_mem[i] = 8'($urandom);
      applyStimulus(24'($urandom), $urandom_range(1, 11), $urandom, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
